// File: rtl/matrix_add_sched_if.sv
// rtl/matrix_add_sched_if.sv - requester/result handshake bundle for the matrix adder scheduler
interface matrix_add_sched_if #(
    parameter int FLAT_W = 27
);
    logic              req0_valid;
    logic              req0_ready;
    logic [FLAT_W-1:0] req0_a;
    logic [FLAT_W-1:0] req0_b;
    logic              req1_valid;
    logic              req1_ready;
    logic [FLAT_W-1:0] req1_a;
    logic [FLAT_W-1:0] req1_b;
    logic              res_valid;
    logic              res_ready;
    logic [FLAT_W-1:0] res_data;
    logic              res_id;

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  res_valid, res_data, res_id,
        output res_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output res_valid, res_data, res_id,
        input  res_ready
    );
endinterface

// File: rtl/matrix_add_sched.sv
// rtl/matrix_add_sched.sv - round-robin shared scheduler for a sequenced element-wise matrix adder
module matrix_add_sched #(
    parameter int ELEM_W   = 3,
    parameter int DIM      = 3,
    parameter int SATURATE = 0
) (
    input  logic                clk,
    input  logic                rst,
    matrix_add_sched_if.slave   bus,
    output logic                busy
);
    localparam int NELEM  = DIM * DIM;
    localparam int FLAT_W = NELEM * ELEM_W;
    localparam int IDX_W  = (NELEM > 1) ? $clog2(NELEM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NELEM - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [FLAT_W-1:0]  op_a;
    logic [FLAT_W-1:0]  op_b;
    logic [FLAT_W-1:0]  acc;
    logic [FLAT_W-1:0]  acc_nxt;
    logic [IDX_W-1:0]   idx;
    logic               owner;
    logic               last;
    logic               grant0;
    logic               grant1;
    logic               accept0;
    logic               accept1;
    logic               last_elem;
    logic [ELEM_W-1:0]  el_a;
    logic [ELEM_W-1:0]  el_b;
    logic [ELEM_W-1:0]  el_sum;
    logic [ELEM_W:0]    raw_sum;
    int                 base;

    // Round-robin grant: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant0 = bus.req0_valid && (!bus.req1_valid || last);
        grant1 = bus.req1_valid && (!bus.req0_valid || !last);
    end

    assign bus.req0_ready = (state == IDLE) && !rst && grant0;
    assign bus.req1_ready = (state == IDLE) && !rst && grant1;
    assign accept0        = bus.req0_valid && bus.req0_ready;
    assign accept1        = bus.req1_valid && bus.req1_ready;
    assign bus.res_valid  = (state == DONE);
    assign busy           = (state != IDLE);
    assign last_elem      = (idx == LAST_IDX);

    // Single adder lane: add element idx and splice it into the running result.
    always_comb begin
        base    = int'(idx) * ELEM_W;
        el_a    = op_a[base +: ELEM_W];
        el_b    = op_b[base +: ELEM_W];
        raw_sum = {1'b0, el_a} + {1'b0, el_b};
        if ((SATURATE != 0) && raw_sum[ELEM_W]) begin
            el_sum = '1;
        end else begin
            el_sum = raw_sum[ELEM_W-1:0];
        end
        acc_nxt               = acc;
        acc_nxt[base +: ELEM_W] = el_sum;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept -> sequence every element -> hold until the result is taken.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept0 || accept1) state_nxt = ADD;
            ADD:     if (last_elem)          state_nxt = DONE;
            DONE:    if (bus.res_ready)      state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    // Operand capture, element sequencing and result publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a         <= '0;
            op_b         <= '0;
            acc          <= '0;
            idx          <= '0;
            owner        <= 1'b0;
            last         <= 1'b1;
            bus.res_data <= '0;
            bus.res_id   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept0) begin
                        op_a  <= bus.req0_a;
                        op_b  <= bus.req0_b;
                        owner <= 1'b0;
                        last  <= 1'b0;
                        idx   <= '0;
                        acc   <= '0;
                    end else if (accept1) begin
                        op_a  <= bus.req1_a;
                        op_b  <= bus.req1_b;
                        owner <= 1'b1;
                        last  <= 1'b1;
                        idx   <= '0;
                        acc   <= '0;
                    end
                end
                ADD: begin
                    acc <= acc_nxt;
                    if (last_elem) begin
                        idx          <= '0;
                        bus.res_data <= acc_nxt;
                        bus.res_id   <= owner;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_add_sched.sv
// tb/tb_matrix_add_sched.sv - self-checking bench for matrix_add_sched (wrap and saturate builds)
module tb_matrix_add_sched;
    localparam int FW      = 27;
    localparam int NEL     = 9;
    localparam int DONE_PH = NEL + 1;

    logic clk = 1'b0;
    logic rst;
    logic busy_w;
    logic busy_s;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    matrix_add_sched_if #(.FLAT_W(FW)) bw();
    matrix_add_sched_if #(.FLAT_W(FW)) bs();

    assign bs.req0_valid = bw.req0_valid;
    assign bs.req0_a     = bw.req0_a;
    assign bs.req0_b     = bw.req0_b;
    assign bs.req1_valid = bw.req1_valid;
    assign bs.req1_a     = bw.req1_a;
    assign bs.req1_b     = bw.req1_b;
    assign bs.res_ready  = bw.res_ready;

    matrix_add_sched #(.ELEM_W(3), .DIM(3), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .bus(bw.slave), .busy(busy_w));
    matrix_add_sched #(.ELEM_W(3), .DIM(3), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .bus(bs.slave), .busy(busy_s));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0o expected %0o (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [26:0] madd(input logic [26:0] a, input logic [26:0] b, input bit sat);
        logic [26:0] r;
        int s;
        r = '0;
        for (int k = 0; k < NEL; k++) begin
            s = int'(a[k*3 +: 3]) + int'(b[k*3 +: 3]);
            if (s > 7) s = sat ? 7 : s - 8;
            r[k*3 +: 3] = 3'(s);
        end
        return r;
    endfunction

    // Behavioural model: phase 0 idle, 1..NEL adding, DONE_PH holding a result.
    int          ph = 0;
    bit          mlast = 1'b1;
    bit          minit = 1'b0;
    bit          mid = 1'b0;
    bit          mrid = 1'b0;
    logic [26:0] ma = '0;
    logic [26:0] mb = '0;
    logic [26:0] mrw = '0;
    logic [26:0] mrs = '0;

    always @(negedge clk) begin
        bit e_r0;
        bit e_r1;
        e_r0 = !rst && ph == 0 && bw.req0_valid && (!bw.req1_valid || mlast);
        e_r1 = !rst && ph == 0 && bw.req1_valid && (!bw.req0_valid || !mlast);
        if (minit) begin
            chk("w_req0_ready", bw.req0_ready, e_r0);
            chk("w_req1_ready", bw.req1_ready, e_r1);
            chk("s_req0_ready", bs.req0_ready, e_r0);
            chk("s_req1_ready", bs.req1_ready, e_r1);
            chk("one_ready", bw.req0_ready & bw.req1_ready, 0);
            chk("w_res_valid", bw.res_valid, ph == DONE_PH);
            chk("s_res_valid", bs.res_valid, ph == DONE_PH);
            chk("w_busy", busy_w, ph != 0);
            chk("s_busy", busy_s, ph != 0);
            chk("w_res_data", bw.res_data, mrw);
            chk("s_res_data", bs.res_data, mrs);
            chk("w_res_id", bw.res_id, mrid);
            chk("s_res_id", bs.res_id, mrid);
        end
        if (rst) begin
            ph = 0; mlast = 1'b1; mrw = '0; mrs = '0; mrid = 1'b0; minit = 1'b1;
        end else if (minit) begin
            if (ph == 0) begin
                if (e_r0) begin
                    ma = bw.req0_a; mb = bw.req0_b; mid = 1'b0; mlast = 1'b0; ph = 1;
                end else if (e_r1) begin
                    ma = bw.req1_a; mb = bw.req1_b; mid = 1'b1; mlast = 1'b1; ph = 1;
                end
            end else if (ph <= NEL) begin
                ph++;
                if (ph == DONE_PH) begin
                    mrw = madd(ma, mb, 1'b0); mrs = madd(ma, mb, 1'b1); mrid = mid;
                end
            end else if (bw.res_ready) begin
                ph = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit id, output bit got);
        got = 1'b0;
        #1;
        for (int n = 0; n < 30; n++) begin
            if (id ? bw.req1_ready : bw.req0_ready) begin
                got = 1'b1;
                break;
            end
            tick();
            #1;
        end
        chk("accept_timeout", got, 1);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!bw.res_valid && n < 30) begin
            tick();
            n++;
        end
        chk("res_valid_timeout", bw.res_valid, 1);
    endtask

    task automatic do_op(input bit id, input logic [26:0] a, input logic [26:0] b, input bit scramble,
                         output int lat, output logic [26:0] rw, output logic [26:0] rs, output bit rid);
        bit got;
        bw.res_ready = 1'b1;
        if (id == 1'b0) begin
            bw.req0_a = a; bw.req0_b = b; bw.req0_valid = 1'b1;
        end else begin
            bw.req1_a = a; bw.req1_b = b; bw.req1_valid = 1'b1;
        end
        wait_ready(id, got);
        tick();
        bw.req0_valid = 1'b0;
        bw.req1_valid = 1'b0;
        if (scramble) begin
            bw.req0_a = ~a; bw.req0_b = ~b; bw.req1_a = ~a; bw.req1_b = ~b;
        end
        lat = 1;
        while (!bw.res_valid && lat < 30) begin
            tick();
            lat++;
        end
        rw  = bw.res_data;
        rs  = bs.res_data;
        rid = bw.res_id;
        tick();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [26:0] rw;
        logic [26:0] rs;
        bit          rid;
        bit          got;
        int          ids[$];
        int          cycs[$];
        logic [26:0] datas[$];
        int          n;
        logic [26:0] held;

        rst = 1'b1;
        bw.req0_valid = 1'b1; bw.req0_a = 27'o123456701; bw.req0_b = 27'o111111111;
        bw.req1_valid = 1'b0; bw.req1_a = '0; bw.req1_b = '0;
        bw.res_ready = 1'b0;
        tick();
        tick();
        chk("rst_req0_ready", bw.req0_ready, 0);
        chk("rst_busy", busy_w, 0);
        chk("rst_res_valid", bw.res_valid, 0);
        chk("rst_res_data", bw.res_data, 0);
        chk("rst_res_id", bw.res_id, 0);
        bw.req0_valid = 1'b0;
        rst = 1'b0;

        // Model pins.
        chk("model_wrap", madd(27'o123456701, 27'o111111111, 1'b0), 27'o234567012);
        chk("model_sat", madd(27'o123456701, 27'o111111111, 1'b1), 27'o234567712);
        chk("model_sat2", madd(27'o777000444, 27'o111000333, 1'b1), 27'o777000777);

        // Single ops: latency, wrap and saturate.
        do_op(1'b0, 27'o123456701, 27'o111111111, 1'b0, lat, rw, rs, rid);
        chk("op1_latency", lat, 10);
        chk("op1_wrap", rw, 27'o234567012);
        chk("op1_sat", rs, 27'o234567712);
        chk("op1_id", rid, 0);
        do_op(1'b1, 27'o777000444, 27'o111000333, 1'b0, lat, rw, rs, rid);
        chk("op2_wrap", rw, 27'o000000777);
        chk("op2_sat", rs, 27'o777000777);
        chk("op2_id", rid, 1);

        // Operands change right after accept; result uses latched values.
        do_op(1'b0, 27'o765432100, 27'o001122334, 1'b1, lat, rw, rs, rid);
        chk("scr_wrap", rw, 27'o766554434);
        chk("scr_sat", rs, 27'o766554434);

        // Contention from reset: 0,1,0 at one op per 11 cycles.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bw.res_ready = 1'b1;
        bw.req0_a = 27'o123456701; bw.req0_b = 27'o111111111; bw.req0_valid = 1'b1;
        bw.req1_a = 27'o777000444; bw.req1_b = 27'o111000333; bw.req1_valid = 1'b1;
        n = 0;
        while (ids.size() < 3 && n < 60) begin
            tick();
            n++;
            if (bw.res_valid && bw.res_ready) begin
                ids.push_back(int'(bw.res_id));
                cycs.push_back(cyc);
                datas.push_back(bw.res_data);
            end
        end
        bw.req0_valid = 1'b0;
        bw.req1_valid = 1'b0;
        chk("cont_count", ids.size(), 3);
        if (ids.size() == 3) begin
            chk("cont_id0", ids[0], 0);
            chk("cont_id1", ids[1], 1);
            chk("cont_id2", ids[2], 0);
            chk("cont_data0", datas[0], 27'o234567012);
            chk("cont_data1", datas[1], 27'o000000777);
            chk("cont_gap01", cycs[1] - cycs[0], 11);
            chk("cont_gap12", cycs[2] - cycs[1], 11);
        end
        tick();
        tick();

        // Backpressure with a waiting requester.
        bw.res_ready = 1'b0;
        bw.req0_a = 27'o123456701; bw.req0_b = 27'o111111111; bw.req0_valid = 1'b1;
        wait_ready(1'b0, got);
        tick();
        bw.req0_valid = 1'b0;
        bw.req1_a = 27'o777000444; bw.req1_b = 27'o111000333; bw.req1_valid = 1'b1;
        wait_valid();
        held = bw.res_data;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", bw.res_valid, 1);
            chk("bp_data", bw.res_data, 27'o234567012);
            chk("bp_hold", bw.res_data, held);
            chk("bp_id", bw.res_id, 0);
            chk("bp_busy", busy_w, 1);
            chk("bp_req1_ready", bw.req1_ready, 0);
            tick();
        end
        bw.res_ready = 1'b1;
        tick();
        chk("bp_valid_drop", bw.res_valid, 0);
        chk("bp_next_accept", bw.req1_ready, 1);
        tick();
        bw.req1_valid = 1'b0;
        wait_valid();
        chk("bp2_data", bw.res_data, 27'o000000777);
        chk("bp2_id", bw.res_id, 1);
        tick();

        // Reset at element 4 of a req0 op.
        bw.req0_a = 27'o123456701; bw.req0_b = 27'o111111111; bw.req0_valid = 1'b1;
        wait_ready(1'b0, got);
        tick();
        bw.req0_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_res_valid", bw.res_valid, 0);
        chk("mr_busy", busy_w, 0);
        chk("mr_res_data", bw.res_data, 0);
        chk("mr_res_id", bw.res_id, 0);
        bw.req0_valid = 1'b1;
        bw.req1_valid = 1'b1;
        #1;
        chk("mr_tie_req0", bw.req0_ready, 1);
        chk("mr_tie_req1", bw.req1_ready, 0);
        bw.req0_valid = 1'b0;
        bw.req1_valid = 1'b0;
        do_op(1'b1, 27'o777000444, 27'o111000333, 1'b0, lat, rw, rs, rid);
        chk("mr_op_latency", lat, 10);
        chk("mr_op_wrap", rw, 27'o000000777);
        chk("mr_op_sat", rs, 27'o777000777);
        chk("mr_op_id", rid, 1);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
